// File: rtl/segment_pkg.sv
// Shared types, default widths and helpers for the SEGMENTATION group.
package segment_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } if_id_state_e;

  localparam int DEF_PC_W     = 21;
  localparam int DEF_INSTR_W  = 21;
  localparam int DEF_OPC_W    = 5;
  localparam int DEF_FIELD_W  = 4;
  localparam int DEF_N_FIELDS = 4;
  localparam int DEF_CNT_W    = 16;

  // Extract operand field k of width fw; field 0 sits in the instruction LSBs.
  // The instruction is zero-extended to 64 bits so one helper serves every width.
  function automatic logic [63:0] slice_field(input logic [63:0] instr,
                                              input int          k,
                                              input int          fw);
    logic [63:0] mask;
    mask = (64'd1 << fw) - 64'd1;
    return (instr >> (k * fw)) & mask;
  endfunction

endpackage

// File: rtl/if_id_entry.sv
// One IF/ID storage entry: a PC plus instruction register with load enable.
module if_id_entry
  import segment_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Capture a beat on load; reset clears so no stale data is ever visible after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/segment_if_id_pipe.sv
// IF/ID pipeline stage: main entry plus one-entry skid buffer, field slicing,
// flush support and a saturating stall counter.
module segment_if_id_pipe
  import segment_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int OPC_W    = DEF_OPC_W,
  parameter int FIELD_W  = DEF_FIELD_W,
  parameter int N_FIELDS = DEF_N_FIELDS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PC_W-1:0]             pc_out,
  input  logic [INSTR_W-1:0]          instruction,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_W-1:0]             pc,
  output logic [OPC_W-1:0]            opcode,
  output logic [N_FIELDS*FIELD_W-1:0] fields,
  output logic [1:0]                  occupancy,
  output logic [CNT_W-1:0]            stall_cnt
);

  if (OPC_W + N_FIELDS * FIELD_W != INSTR_W) begin : g_width_check
    $error("segment_if_id_pipe: OPC_W + N_FIELDS*FIELD_W must equal INSTR_W");
  end

  if_id_state_e       state_q, state_d;
  logic               in_ready_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               accept, take;
  logic               main_load, main_from_skid, skid_load;

  logic [PC_W-1:0]    main_pc, skid_pc, main_pc_in;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_in;

  assign accept = in_valid && in_ready_q;
  assign take   = out_valid && out_ready;

  // Next-state and entry-load control; flush empties the stage and drops any accepted beat.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so fetch never sees out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign main_pc_in    = main_from_skid ? skid_pc    : pc_out;
  assign main_instr_in = main_from_skid ? skid_instr : instruction;

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .pc_i    (main_pc_in),
    .instr_i (main_instr_in),
    .pc_o    (main_pc),
    .instr_o (main_instr)
  );

  if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .pc_i    (pc_out),
    .instr_i (instruction),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Stall counter next value: counts unserved valid cycles, saturating, ignored during flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Occupancy and valid decode straight from the state.
  always_comb begin
    occupancy = 2'd0;
    out_valid = 1'b0;
    unique case (state_q)
      EMPTY:   begin occupancy = 2'd0; out_valid = 1'b0; end
      ONE:     begin occupancy = 2'd1; out_valid = 1'b1; end
      FULL:    begin occupancy = 2'd2; out_valid = 1'b1; end
      default: begin occupancy = 2'd0; out_valid = 1'b0; end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign pc        = main_pc;
  assign opcode    = main_instr[INSTR_W-1 -: OPC_W];
  assign stall_cnt = stall_cnt_q;

  for (genvar k = 0; k < N_FIELDS; k++) begin : g_fields
    assign fields[k*FIELD_W +: FIELD_W] = FIELD_W'(slice_field(64'(main_instr), k, FIELD_W));
  end

endmodule

// File: tb/tb_segment_if_id_pipe.sv
// Directed bench for segment_if_id_pipe: default build plus a 32-bit reparametrised build.
module tb_segment_if_id_pipe;

  localparam logic [20:0] INSTR_A = 21'b110110110110110110110;
  localparam logic [20:0] INSTR_B = 21'b101010101010101010101;
  localparam logic [31:0] INSTR_C = 32'hA53CF196;

  logic clk = 1'b0;
  logic rst;

  logic        inValid, inReady, flush, outValid, outReady;
  logic [20:0] pcIn, instrIn, pcOut;
  logic [4:0]  opcodeOut;
  logic [15:0] fieldsOut, stallCnt;
  logic [1:0]  occupancy;

  logic        inValidB, inReadyB, flushB, outValidB, outReadyB;
  logic [20:0] pcInB, pcOutB;
  logic [31:0] instrInB;
  logic [7:0]  opcodeOutB;
  logic [23:0] fieldsOutB;
  logic [1:0]  occupancyB;
  logic [2:0]  stallCntB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  segment_if_id_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .pc_out      (pcIn),
    .instruction (instrIn),
    .flush       (flush),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .pc          (pcOut),
    .opcode      (opcodeOut),
    .fields      (fieldsOut),
    .occupancy   (occupancy),
    .stall_cnt   (stallCnt)
  );

  segment_if_id_pipe #(
    .INSTR_W (32), .OPC_W (8), .FIELD_W (6), .N_FIELDS (4), .CNT_W (3)
  ) dutWide (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValidB),
    .in_ready    (inReadyB),
    .pc_out      (pcInB),
    .instruction (instrInB),
    .flush       (flushB),
    .out_valid   (outValidB),
    .out_ready   (outReadyB),
    .pc          (pcOutB),
    .opcode      (opcodeOutB),
    .fields      (fieldsOutB),
    .occupancy   (occupancyB),
    .stall_cnt   (stallCntB)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the default-width DUT for one cycle, then step past the edge.
  task automatic applyStimulus(input logic v, input logic [20:0] p, input logic [20:0] ins,
                               input logic rdy, input logic fl);
    inValid  = v;
    pcIn     = p;
    instrIn  = ins;
    outReady = rdy;
    flush    = fl;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    inValid = 0; pcIn = '0; instrIn = '0; outReady = 0; flush = 0;
    inValidB = 0; pcInB = '0; instrInB = '0; outReadyB = 0; flushB = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_pc", 64'(pcOut), 64'd0);
    checkOutput("rst_opcode", 64'(opcodeOut), 64'd0);
    checkOutput("rst_fields", 64'(fieldsOut), 64'd0);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);
    checkOutput("rst_stall", 64'(stallCnt), 64'd0);

    // Streaming with out_ready high: one-cycle latency, full throughput
    applyStimulus(1, 21'd100, INSTR_A, 1, 0);
    checkOutput("s1_valid", 64'(outValid), 64'd1);
    checkOutput("s1_pc", 64'(pcOut), 64'd100);
    checkOutput("s1_opcode", 64'(opcodeOut), 64'h1B);
    checkOutput("s1_fields", 64'(fieldsOut), 64'h6DB6);
    applyStimulus(1, 21'd200, INSTR_B, 1, 0);
    checkOutput("s2_pc", 64'(pcOut), 64'd200);
    checkOutput("s2_opcode", 64'(opcodeOut), 64'h15);
    checkOutput("s2_fields", 64'(fieldsOut), 64'h5555);
    applyStimulus(1, 21'd300, INSTR_A, 1, 0);
    checkOutput("s3_pc", 64'(pcOut), 64'd300);
    checkOutput("s3_occ", 64'(occupancy), 64'd1);
    applyStimulus(0, 21'd0, 21'd0, 1, 0);
    checkOutput("s_drain_valid", 64'(outValid), 64'd0);
    checkOutput("s_stall", 64'(stallCnt), 64'd0);

    // Backpressure: fill main and skid, hold, then drain in order
    applyStimulus(1, 21'd100, INSTR_A, 0, 0);
    checkOutput("bp1_pc", 64'(pcOut), 64'd100);
    checkOutput("bp1_occ", 64'(occupancy), 64'd1);
    applyStimulus(1, 21'd200, INSTR_B, 0, 0);
    checkOutput("bp2_occ", 64'(occupancy), 64'd2);
    checkOutput("bp2_in_ready", 64'(inReady), 64'd0);
    checkOutput("bp2_pc", 64'(pcOut), 64'd100);
    applyStimulus(1, 21'd300, INSTR_A, 0, 0);
    applyStimulus(0, 21'd0, 21'd0, 0, 0);
    checkOutput("bp_hold_pc", 64'(pcOut), 64'd100);
    checkOutput("bp_hold_opcode", 64'(opcodeOut), 64'h1B);
    checkOutput("bp_hold_stall", 64'(stallCnt), 64'd3);
    applyStimulus(0, 21'd0, 21'd0, 1, 0);
    checkOutput("bp_rel_pc", 64'(pcOut), 64'd200);
    checkOutput("bp_rel_opcode", 64'(opcodeOut), 64'h15);
    checkOutput("bp_rel_occ", 64'(occupancy), 64'd1);
    checkOutput("bp_rel_in_ready", 64'(inReady), 64'd1);
    applyStimulus(0, 21'd0, 21'd0, 1, 0);
    checkOutput("bp_end_valid", 64'(outValid), 64'd0);
    checkOutput("bp_end_stall", 64'(stallCnt), 64'd3);

    // Flush while FULL with a beat offered
    applyStimulus(1, 21'd100, INSTR_A, 0, 0);
    applyStimulus(1, 21'd200, INSTR_B, 0, 0);
    checkOutput("fl_pre_occ", 64'(occupancy), 64'd2);
    applyStimulus(1, 21'd300, INSTR_A, 0, 1);
    checkOutput("fl_valid", 64'(outValid), 64'd0);
    checkOutput("fl_occ", 64'(occupancy), 64'd0);
    checkOutput("fl_in_ready", 64'(inReady), 64'd1);
    checkOutput("fl_stall", 64'(stallCnt), 64'd4);
    // A beat accepted during a flush cycle is dropped
    applyStimulus(1, 21'd300, INSTR_A, 1, 1);
    checkOutput("fl_acc_valid", 64'(outValid), 64'd0);
    applyStimulus(0, 21'd0, 21'd0, 1, 0);
    checkOutput("fl_after_valid", 64'(outValid), 64'd0);
    checkOutput("fl_after_occ", 64'(occupancy), 64'd0);

    // Reset mid-stream with both entries held
    applyStimulus(1, 21'd100, INSTR_A, 0, 0);
    applyStimulus(1, 21'd200, INSTR_B, 0, 0);
    checkOutput("mr_pre_occ", 64'(occupancy), 64'd2);
    checkOutput("mr_pre_stall", 64'(stallCnt), 64'd5);
    rst = 1'b1;
    applyStimulus(0, 21'd0, 21'd0, 0, 0);
    rst = 1'b0;
    checkOutput("mr_valid", 64'(outValid), 64'd0);
    checkOutput("mr_pc", 64'(pcOut), 64'd0);
    checkOutput("mr_opcode", 64'(opcodeOut), 64'd0);
    checkOutput("mr_fields", 64'(fieldsOut), 64'd0);
    checkOutput("mr_occ", 64'(occupancy), 64'd0);
    checkOutput("mr_stall", 64'(stallCnt), 64'd0);
    checkOutput("mr_in_ready", 64'(inReady), 64'd1);
    applyStimulus(0, 21'd0, 21'd0, 1, 0);
    checkOutput("mr_after_valid", 64'(outValid), 64'd0);

    // Wide build: slicing and counter saturation
    inValidB = 1; pcInB = 21'd7; instrInB = INSTR_C; outReadyB = 0;
    tick();
    inValidB = 0;
    checkOutput("w_valid", 64'(outValidB), 64'd1);
    checkOutput("w_pc", 64'(pcOutB), 64'd7);
    checkOutput("w_opcode", 64'(opcodeOutB), 64'hA5);
    checkOutput("w_field0", 64'(fieldsOutB[5:0]), 64'h16);
    checkOutput("w_field1", 64'(fieldsOutB[11:6]), 64'h06);
    checkOutput("w_field3", 64'(fieldsOutB[23:18]), 64'h0F);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("w_stall_sat", 64'(stallCntB), 64'd7);
    checkOutput("w_hold_pc", 64'(pcOutB), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_if_id_pipe.md
# segment_if_id_pipe

Parametrised IF/ID pipeline stage placed between instruction fetch and decode in the processor's SEGMENTATION group. Registers PC and instruction under a valid/ready handshake with a one-entry skid buffer, so fetch never has to combinationally observe a decode stall. Splits the held instruction into an opcode plus N equal-width operand fields, supports a pipeline flush, and counts stall cycles for performance debug.

## Interface
- `PC_W`, default 21: program-counter width.
- `INSTR_W`, default 21: instruction width.
- `OPC_W`, default 5: opcode width, taken from the instruction MSBs.
- `FIELD_W`, default 4: width of each operand field.
- `N_FIELDS`, default 4: number of operand fields. `OPC_W + N_FIELDS*FIELD_W` must equal `INSTR_W`; elaboration fails otherwise.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents a beat.
- `in_ready`  out  1  stage accepts a beat. Registered.
- `pc_out`  in  PC_W  fetch PC.
- `instruction`  in  INSTR_W  fetched instruction.
- `flush`  in  1  kill all held beats, e.g. on a taken branch.
- `out_valid`  out  1  decode beat valid.
- `out_ready`  in  1  decode accepts.
- `pc`  out  PC_W  held PC.
- `opcode`  out  OPC_W  `instruction[INSTR_W-1 -: OPC_W]`.
- `fields`  out  N_FIELDS×FIELD_W  field k = `instruction[(k+1)*FIELD_W-1 -: FIELD_W]`. Field 0 is the LSBs.
- `occupancy`  out  2  number of held beats, 0 to 2.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Two storage entries:
  - Main: drives the outputs.
  - Skid: holds an overflow beat.
- FSM states and their outputs:
  - EMPTY: occupancy 0, `out_valid=0`, `in_ready=1`.
  - ONE: occupancy 1, `out_valid=1`, `in_ready=1`.
  - FULL: occupancy 2, `out_valid=1`, `in_ready=0`.
- Definitions: accept = `in_valid && in_ready`; take = `out_valid && out_ready`.
- Transitions when `flush=0`:
  - EMPTY + accept → ONE. Main is loaded.
  - ONE + accept + take → ONE. Main is replaced by the new beat.
  - ONE + accept + !take → FULL. Skid is loaded.
  - ONE + !accept + take → EMPTY.
  - ONE + !accept + !take → ONE. Main is held.
  - FULL + take → ONE. Skid moves to main.
  - FULL + !take → FULL. No input is accepted because `in_ready=0`.
- Flush:
  - Next state is EMPTY in every state. Both entries are invalidated.
  - A beat accepted in the flush cycle is discarded.
  - A take in the flush cycle still completes normally toward decode.
- Register contents on flush: data registers keep stale contents, but `out_valid=0` masks them.
- Register contents on reset: all data registers clear to 0.
- `stall_cnt`:
  - Increments when `out_valid && !out_ready && !flush`.
  - Saturates at all-ones.
  - Clears only on `rst`.
- Field slicing is purely combinational from the main-entry instruction register. No extra latency.

## Timing
- Reset (synchronous, takes effect at the edge where `rst=1`):
  - State is EMPTY.
  - `in_ready=1`, `out_valid=0`.
  - `pc`, `opcode`, `fields` = 0.
  - `occupancy=0`, `stall_cnt=0`.
- Reset asserted mid-operation drops any held beats. No partial transfer is presented afterward.
- Latency:
  - A beat accepted at edge N appears on the outputs with `out_valid=1` after edge N.
  - Latency is 1 cycle. Throughput is 1 beat per cycle while `out_ready=1`.
- `in_ready` is a flop output. It is derived from next state != FULL, so it has no combinational path from `out_ready`.
- Output data is stable while `out_valid && !out_ready`.
- Beat order is strictly FIFO: main before skid.
- If `rst` and `flush` are both high, `rst` dominates, so `stall_cnt` is also cleared.

## Structure
- Package `segment_pkg` holds:
  - The `if_id_state_e` enum {EMPTY, ONE, FULL}.
  - Default width localparams.
  - The shared field-slicing function `slice_field(instr, k)`.
- Sub-module `if_id_entry`: one PC+instruction register with load enable and synchronous clear. Instantiated twice, as main and skid.
- The top level holds the FSM, the handshake, and the counter.

## Test plan
- Reset with default parameters: assert `rst` for 2 cycles → all outputs 0, `in_ready=1`, `occupancy=0`.
- Stream: `pc_out`=100/200/300 with `instruction`=`21'b110110110110110110110` and `21'b101010101010101010101`, `out_ready=1` → each beat appears 1 cycle later. For `21'b110110110110110110110`: opcode=`11011`, fields[3..0]=`0110,1101,1011,0110`.
- Backpressure: `out_ready=0`, push PC 100 then 200 → occupancy 2, `in_ready=0`, `pc` held at 100. Release → 100 then 200 in order, and `stall_cnt` equals the stalled cycles.
- Flush while FULL with `in_valid=1` (PC 300) → next cycle EMPTY, `out_valid=0`, and PC 300 is never output.
- Reset mid-stream while occupancy is 2 → next cycle all outputs 0, with no residual beat.
- Reparametrise with `INSTR_W=32`, `OPC_W=8`, `FIELD_W=6`, `N_FIELDS=4`, `CNT_W=3`: check the field slicing, and hold a stall for 10 cycles → `stall_cnt` saturates at 7.
